// File: rtl/ula_pkg.sv
// ula_pkg: shared types for the ULA video RAM port (address type,
// posted-write record and the CPU-side state encoding).
package ula_pkg;

  localparam int VRAM_AW = 13;

  typedef logic [VRAM_AW-1:0] vram_addr_t;

  typedef struct packed {
    vram_addr_t  addr;
    logic [7:0]  data;
  } vram_wr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2
  } cpu_state_t;

  function automatic vram_wr_t pack_wr(input vram_addr_t a, input logic [7:0] d);
    vram_wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

endpackage

// File: rtl/vram_post_fifo.sv
// vram_post_fifo: small synchronous FIFO of posted CPU writes.
// The caller only pushes when not full (or when popping the same cycle)
// and only pops when not empty; a push into a full FIFO alongside a pop
// reuses the slot being read out this cycle.
module vram_post_fifo
  import ula_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_reset,
  input  logic     i_push,
  input  vram_wr_t i_wr,
  input  logic     i_pop,
  output vram_wr_t o_rd,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  vram_wr_t    r_buf [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rd    = r_buf[r_rptr[AW-1:0]];

  // Read/write pointers with a wrap bit to tell full from empty
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Entry storage, no reset needed
  always_ff @(posedge i_clk) begin
    if (i_push) r_buf[r_wptr[AW-1:0]] <= i_wr;
  end

endmodule

// File: rtl/ula_vram_port.sv
// ula_vram_port: single-port 8 KB screen memory shared between the video
// fetcher (fixed one-cycle read latency, pixel clock) and the Z80 side.
// A cycle whose vram_address differs from the previous one (or the first
// cycle after reset) belongs to the video fetcher; every other cycle is
// free for the CPU.
// Optional feature: define VRAM_WRITE_POST_EN to post CPU writes through
// a POST_DEPTH-entry FIFO that drains in idle cycles. Without it, writes
// take the same wait-for-idle path as reads.
module ula_vram_port
  import ula_pkg::*;
#(
  parameter int DEPTH      = 8192,
  parameter int POST_DEPTH = 4
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic [12:0] vram_address,
  output logic [7:0]  vram_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata
);

  if (POST_DEPTH < 2 || POST_DEPTH > 16 || (POST_DEPTH & (POST_DEPTH - 1)) != 0) begin : g_bad_post_depth
    $error("POST_DEPTH must be a power of two in 2..16");
  end

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_mem_q;
  vram_addr_t r_last_va;
  logic       r_first;
  logic       r_vid_d;
  logic [7:0] r_vid_hold;
  cpu_state_t r_state;
  vram_addr_t r_addr;
  logic       r_ack;
  logic [7:0] r_rdata;

  logic       w_vslot;
  logic       w_cpu_slot;
  logic       w_rd_go;
  logic       w_wr_go;
  logic       w_mem_re;
  vram_addr_t w_rd_addr;
  vram_addr_t w_wr_addr;
  logic [7:0] w_wr_data;

  // Video owns the port whenever the fetch address moves; nothing else
  // touches memory in that cycle, so a CPU write to the fetched address
  // always lands afterwards and video sees the old byte.
  assign w_vslot    = r_first | (vram_address != r_last_va);
  assign w_cpu_slot = ~reset & ~w_vslot;

`ifdef VRAM_WRITE_POST_EN
  logic     w_push;
  logic     w_pop;
  logic     w_fifo_full;
  logic     w_fifo_empty;
  vram_wr_t w_fifo_rd;

  // Draining beats a pending read; the read waits for an empty FIFO so it
  // never overtakes an earlier posted write.
  assign w_pop     = w_cpu_slot & ~w_fifo_empty;
  assign w_push    = ~reset & (r_state == IDLE) & cpu_req & cpu_we & (~w_fifo_full | w_pop);
  assign w_wr_go   = w_pop;
  assign w_wr_addr = w_fifo_rd.addr;
  assign w_wr_data = w_fifo_rd.data;
  assign w_rd_go   = w_cpu_slot & (r_state == RD_WAIT) & w_fifo_empty;

  vram_post_fifo #(
    .DEPTH (POST_DEPTH)
  ) u_post_fifo (
    .i_clk   (clk_pix),
    .i_reset (reset),
    .i_push  (w_push),
    .i_wr    (pack_wr(cpu_addr, cpu_wdata)),
    .i_pop   (w_pop),
    .o_rd    (w_fifo_rd),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );
`else
  logic       r_we;
  logic [7:0] r_wdata;

  assign w_wr_go   = w_cpu_slot & (r_state == RD_WAIT) & r_we;
  assign w_rd_go   = w_cpu_slot & (r_state == RD_WAIT) & ~r_we;
  assign w_wr_addr = r_addr;
  assign w_wr_data = r_wdata;

  // Capture direction and write data when a request is accepted
  always_ff @(posedge clk_pix) begin
    if (r_state == IDLE && cpu_req) begin
      r_we    <= cpu_we;
      r_wdata <= cpu_wdata;
    end
  end
`endif

  assign w_mem_re  = ~reset & (w_vslot | w_rd_go);
  assign w_rd_addr = w_vslot ? vram_address : r_addr;

  // Single-port memory with registered read; contents survive reset
  always_ff @(posedge clk_pix) begin
    if (w_wr_go)  r_mem[w_wr_addr] <= w_wr_data;
    if (w_mem_re) r_mem_q <= r_mem[w_rd_addr];
  end

  // Video slot tracking and the hold register that hides CPU reads
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      r_last_va  <= '0;
      r_first    <= 1'b1;
      r_vid_d    <= 1'b0;
      r_vid_hold <= 8'h00;
    end else begin
      r_last_va <= vram_address;
      r_first   <= 1'b0;
      r_vid_d   <= w_vslot;
      if (r_vid_d) r_vid_hold <= r_mem_q;
    end
  end

  // Latch the CPU offset when a request is accepted
  always_ff @(posedge clk_pix) begin
    if (r_state == IDLE && cpu_req) r_addr <= cpu_addr;
  end

  // CPU request state machine with registered ack and read data
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
`ifdef VRAM_WRITE_POST_EN
          if (cpu_req && !cpu_we) r_state <= RD_WAIT;
          else if (w_push)        r_ack   <= 1'b1;
`else
          if (cpu_req) r_state <= RD_WAIT;
`endif
        end
        RD_WAIT: begin
          if (w_rd_go) begin
            r_state <= RD_DATA;
`ifndef VRAM_WRITE_POST_EN
          end else if (w_wr_go) begin
            r_ack   <= 1'b1;
            r_state <= IDLE;
`endif
          end
        end
        RD_DATA: begin
          r_rdata <= r_mem_q;
          r_ack   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign vram_data = r_vid_d ? r_mem_q : r_vid_hold;
  assign cpu_ack   = r_ack;
  assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_ula_vram_port.sv
// tb_ula_vram_port: directed bench for ula_vram_port. Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// Build with VRAM_WRITE_POST_EN defined to add the posted-write scenarios.
module tb_ula_vram_port;

  logic        clk_pix = 1'b0;
  logic        reset;
  logic [12:0] vram_address;
  logic [7:0]  vram_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef VRAM_WRITE_POST_EN
  localparam int WR_LAT_MIN = 1;
  localparam int WR_LAT_MAX = 1;
`else
  localparam int WR_LAT_MIN = 2;
  localparam int WR_LAT_MAX = 3;
`endif

  int         lat;
  logic [7:0] rd;
  int         lat_f;
  logic [7:0] rd_f;
  int         n_ack;
  int         ack_cyc [5];
  int         exp_cyc [5] = '{1, 2, 3, 4, 7};
  int         rd_ack_cyc;
  logic [7:0] rd_got;

  always #5 clk_pix = ~clk_pix;

  ula_vram_port dut (
    .clk_pix      (clk_pix),
    .reset        (reset),
    .vram_address (vram_address),
    .vram_data    (vram_data),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that
  // follows the ack cycle. lat counts cycles from request to ack.
  task automatic cpu_xfer(input logic we, input logic [12:0] a, input logic [7:0] d,
                          output int l, output logic [7:0] r);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    l = 99;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_pix);
      if (cpu_ack) begin
        l = c;
        break;
      end
    end
    r       = cpu_rdata;
    cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    cpu_req      = 1'b0;
    cpu_we       = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    vram_address = '0;
    repeat (3) @(posedge clk_pix);
    #1;
    reset = 1'b0;
    @(negedge clk_pix);
    chk("rst_vram_data", 32'(vram_data), 32'h00);
    chk("rst_cpu_ack",   32'(cpu_ack),   32'h0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h00);
    tick();

    // Preload through the CPU port in idle cycles
    cpu_xfer(1'b1, 13'h0000, 8'h3C, lat, rd);
    chk("wr_lat_idle", 32'(lat), 32'(WR_LAT_MIN));
    cpu_xfer(1'b1, 13'h0123, 8'hA5, lat, rd);
    chk("wr_lat_idle2", 32'(lat), 32'(WR_LAT_MIN));
    cpu_xfer(1'b1, 13'h0200, 8'h11, lat, rd);
    for (int k = 0; k < 4; k++) cpu_xfer(1'b1, 13'h0400 + 13'(k), 8'h40 + 8'(k), lat, rd);
    cpu_xfer(1'b1, 13'h0500, 8'h77, lat, rd);

    // Video read latency and hold behaviour
    vram_address = 13'h0123;
    @(negedge clk_pix);
    @(negedge clk_pix);
    chk("vid_a5_n1", 32'(vram_data), 32'hA5);
    tick();
    cpu_xfer(1'b1, 13'h0201, 8'h99, lat, rd);
    chk("vid_hold_after_wr", 32'(vram_data), 32'hA5);
    cpu_xfer(1'b0, 13'h0200, 8'h00, lat, rd);
    chk("rd_0200_data", 32'(rd), 32'h11);
    chk("rd_lat_idle", 32'(lat), 32'd3);
    chk("vid_hold_after_rd", 32'(vram_data), 32'hA5);
    vram_address = 13'h0000;
    @(negedge clk_pix);
    chk("vid_old_in_slot", 32'(vram_data), 32'hA5);
    @(negedge clk_pix);
    chk("vid_3c_n1", 32'(vram_data), 32'h3C);
    tick();

    // Generator pattern (changes at hc 10 and 12) under continuous CPU writes
    fork
      begin
        for (int c = 0; c < 32; c++) begin
          if (c % 16 == 10) vram_address = 13'h0400 + 13'(2 * (c / 16));
          if (c % 16 == 12) vram_address = 13'h0401 + 13'(2 * (c / 16));
          @(negedge clk_pix);
          if (c % 16 == 11) chk("fetch_vid_a", 32'(vram_data), 32'(8'h40 + 8'(2 * (c / 16))));
          if (c % 16 == 13) chk("fetch_vid_b", 32'(vram_data), 32'(8'h41 + 8'(2 * (c / 16))));
          tick();
        end
      end
      begin
        for (int w = 0; w < 8; w++) begin
          cpu_xfer(1'b1, 13'h1800, 8'h5A, lat_f, rd_f);
          chk("fetch_wr_lat", 32'(lat_f >= WR_LAT_MIN && lat_f <= WR_LAT_MAX), 32'h1);
        end
      end
    join
    chk("fetch_vid_stable", 32'(vram_data), 32'h43);
    cpu_xfer(1'b0, 13'h1800, 8'h00, lat, rd);
    chk("rd_1800_data", 32'(rd), 32'h5A);

    // Reset while a read sits in RD_WAIT
    vram_address = 13'h0123;
    tick();
    tick();
    tick();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 13'h0200;
    tick();
    reset   = 1'b1;
    cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk_pix);
    chk("mid_rst_vram_data", 32'(vram_data), 32'h00);
    chk("mid_rst_cpu_rdata", 32'(cpu_rdata), 32'h00);
    chk("mid_rst_cpu_ack",   32'(cpu_ack),   32'h0);
    @(negedge clk_pix);
    chk("mid_rst_first_vid", 32'(vram_data), 32'hA5);
    n_ack = 0;
    for (int c = 0; c < 5; c++) begin
      if (cpu_ack) n_ack++;
      @(negedge clk_pix);
    end
    chk("mid_rst_no_ack", 32'(n_ack), 32'd0);
    tick();

    // Collision: fetch moves onto the address the CPU is writing
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 13'h0500;
    cpu_wdata = 8'hFF;
    lat = 99;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_pix);
      if (c == 2) chk("collide_vid_old", 32'(vram_data), 32'h77);
      if (cpu_ack && cpu_req) begin
        lat     = c;
        cpu_req = 1'b0;
      end
      tick();
      if (c == 0) vram_address = 13'h0500;
    end
`ifdef VRAM_WRITE_POST_EN
    chk("collide_wr_lat", 32'(lat), 32'd1);
`else
    chk("collide_wr_lat", 32'(lat), 32'd3);
`endif
    chk("collide_vid_hold", 32'(vram_data), 32'h77);
    cpu_xfer(1'b0, 13'h0500, 8'h00, lat, rd);
    chk("collide_mem_new", 32'(rd), 32'hFF);

`ifdef VRAM_WRITE_POST_EN
    // Five held writes while video slots block draining: FIFO fills after 4
    n_ack = 0;
    for (int k = 0; k < 5; k++) ack_cyc[k] = 99;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 13'h0700;
    cpu_wdata = 8'hC0;
    for (int c = 0; c < 16; c++) begin
      if (c <= 5) vram_address = (c % 2 == 0) ? 13'h0600 : 13'h0601;
      @(negedge clk_pix);
      if (cpu_ack && n_ack < 5) begin
        ack_cyc[n_ack] = c;
        n_ack++;
        if (n_ack < 5) begin
          cpu_addr  = 13'h0700 + 13'(n_ack);
          cpu_wdata = 8'hC0 + 8'(n_ack);
        end else begin
          cpu_req = 1'b0;
        end
      end
      tick();
    end
    for (int k = 0; k < 5; k++) chk("post_ack_cycle", 32'(ack_cyc[k]), 32'(exp_cyc[k]));
    for (int k = 0; k < 5; k++) begin
      cpu_xfer(1'b0, 13'h0700 + 13'(k), 8'h00, lat, rd);
      chk("post_readback", 32'(rd), 32'(8'hC0 + 8'(k)));
    end

    // Write then immediate read of the same address waits for the drain
    n_ack      = 0;
    rd_ack_cyc = 99;
    rd_got     = 8'h00;
    cpu_req    = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = 13'h0040;
    cpu_wdata  = 8'h33;
    for (int c = 0; c < 16; c++) begin
      if (c <= 3) vram_address = (c % 2 == 0) ? 13'h0600 : 13'h0601;
      @(negedge clk_pix);
      if (cpu_ack) begin
        n_ack++;
        if (cpu_we) begin
          cpu_we = 1'b0;
        end else begin
          rd_ack_cyc = c;
          rd_got     = cpu_rdata;
          cpu_req    = 1'b0;
        end
      end
      tick();
    end
    chk("order_rd_data", 32'(rd_got), 32'h33);
    chk("order_rd_ack_cycle", 32'(rd_ack_cyc), 32'd7);
    chk("order_ack_count", 32'(n_ack), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
